iq_packetizer: RTL and testbench



---
 rtl/iq_packetizer.sv | 168 ++++++++++++++++
 tb/tb_iq_packetizer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_packetizer.sv
// Packs IQ sample words from a show-ahead FIFO into fixed-size Ethernet/IPv4/UDP
// frames on a 32-bit Avalon-ST MAC transmit port; the MAC appends the FCS.
module iq_packetizer #(
    parameter logic [47:0] DST_MAC       = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC       = 48'h0200C0A8010A,
    parameter logic [31:0] SRC_IP        = 32'hC0A8010A,
    parameter logic [31:0] DST_IP        = 32'hC0A80101,
    parameter logic [15:0] SRC_PORT      = 16'd5000,
    parameter logic [15:0] DST_PORT      = 16'd5000,
    parameter int          PAYLOAD_WORDS = 256,
    parameter int          IDLE_GAP      = 4
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        rd_en,
    input  logic [31:0] rd_data,
    input  logic        rd_dr,
    output logic        tx_clk,
    output logic [31:0] tx_data,
    output logic        tx_eop,
    output logic        tx_err,
    output logic [1:0]  tx_mod,
    input  logic        tx_rdy,
    output logic        tx_sop,
    output logic        tx_wren,
    output logic        crc_fwd,
    input  logic        a_full,
    input  logic        a_empty
);

    localparam logic [15:0] UDP_LEN  = 16'(10 + 4 * PAYLOAD_WORDS);
    localparam logic [15:0] IP_LEN   = 16'(UDP_LEN + 16'd20);
    localparam logic [10:0] PAY_LAST = 11'(PAYLOAD_WORDS - 1);
    localparam logic [15:0] GAP_LAST = 16'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic [3:0]  HDR_LAST = 4'd10;

    // Checksum field itself is zero and the id halfword contributes nothing.
    function automatic logic [15:0] ip_checksum();
        logic [31:0] s;
        s = 32'h4500 + 32'(IP_LEN) + 32'h4000 + 32'h4011
          + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0])
          + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return ~s[15:0];
    endfunction

    localparam logic [15:0] IP_CSUM = ip_checksum();

    function automatic logic [31:0] hdr_word(input logic [3:0] h, input logic [15:0] seq);
        logic [31:0] w;
        case (h)
            4'd0:    w = DST_MAC[47:16];
            4'd1:    w = {DST_MAC[15:0], SRC_MAC[47:32]};
            4'd2:    w = SRC_MAC[31:0];
            4'd3:    w = 32'h0800_4500;
            4'd4:    w = {IP_LEN, 16'h0000};
            4'd5:    w = 32'h4000_4011;
            4'd6:    w = {IP_CSUM, SRC_IP[31:16]};
            4'd7:    w = {SRC_IP[15:0], DST_IP[31:16]};
            4'd8:    w = {DST_IP[15:0], SRC_PORT};
            4'd9:    w = {DST_PORT, UDP_LEN};
            4'd10:   w = {16'h0000, seq};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  h_q, h_d;
    logic [10:0] cnt_q, cnt_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] seq_q, seq_d;
    logic        beat;
    logic        unused_a_full;

    assign tx_clk        = clk;
    assign tx_err        = 1'b0;
    assign tx_mod        = 2'b00;
    assign crc_fwd       = 1'b0;
    assign unused_a_full = a_full;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            h_q     <= 4'd0;
            cnt_q   <= 11'd0;
            gap_q   <= 16'd0;
            seq_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            seq_q   <= seq_d;
        end
    end

    // Outputs are decoded from state so they hold while the MAC back-pressures.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        seq_d   = seq_q;
        tx_data = 32'h0;
        tx_wren = 1'b0;
        tx_sop  = 1'b0;
        tx_eop  = 1'b0;
        rd_en   = 1'b0;
        beat    = 1'b0;
        case (state_q)
            IDLE: begin
                h_d   = 4'd0;
                cnt_d = 11'd0;
                if (!a_empty && rd_dr) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                tx_data = hdr_word(h_q, seq_q);
                tx_wren = 1'b1;
                tx_sop  = (h_q == 4'd0);
                if (tx_rdy) begin
                    if (h_q == HDR_LAST) begin
                        state_d = PAYLOAD;
                        cnt_d   = 11'd0;
                    end else begin
                        h_d = h_q + 4'd1;
                    end
                end
            end
            PAYLOAD: begin
                // FIFO word goes straight out; a read only happens on an accepted beat.
                beat    = rd_dr & tx_rdy;
                tx_data = rd_data;
                tx_wren = beat;
                rd_en   = beat;
                tx_eop  = (cnt_q == PAY_LAST);
                if (beat) begin
                    if (cnt_q == PAY_LAST) begin
                        seq_d   = seq_q + 16'd1;
                        gap_d   = 16'd0;
                        state_d = GAP;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_iq_packetizer.sv
// Bench for iq_packetizer: FIFO and MAC models, a frame-level reference model,
// a table of fixed header/payload vectors and directed multi-cycle sequences.
`timescale 1ns/1ps
module tb_iq_packetizer;

    localparam logic [47:0] DST_MAC  = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] SRC_MAC  = 48'h0200C0A8010A;
    localparam logic [31:0] SRC_IP   = 32'hC0A8010A;
    localparam logic [31:0] DST_IP   = 32'hC0A80101;
    localparam logic [15:0] SRC_PORT = 16'd5000;
    localparam logic [15:0] DST_PORT = 16'd5000;
    localparam int PW      = 256;
    localparam int IGAP    = 4;
    localparam int FRAME_W = 11 + PW;

    logic        clk = 1'b0;
    logic        rstn, rd_dr, tx_rdy, a_full, a_empty;
    logic        rd_en, tx_clk, tx_eop, tx_err, tx_sop, tx_wren, crc_fwd;
    logic [1:0]  tx_mod;
    logic [31:0] rd_data, tx_data;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        int          cyc;
    } beat_t;

    typedef struct {
        int          off;
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } vec_t;

    beat_t       beats[$];
    logic [31:0] head = 32'd0;
    int          rd_cnt = 0;
    int          cyc = 0;
    int          hold_seen = 0;
    int          hold_viol = 0;
    logic        pend = 1'b0;
    logic        cons = 1'b0;
    logic [31:0] pd;
    logic        ps, pe;
    int          tests = 0;
    int          fails = 0;

    assign rd_data = head;

    always #5 clk = ~clk;

    iq_packetizer dut (
        .clk     (clk),
        .rstn    (rstn),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rd_dr   (rd_dr),
        .tx_clk  (tx_clk),
        .tx_data (tx_data),
        .tx_eop  (tx_eop),
        .tx_err  (tx_err),
        .tx_mod  (tx_mod),
        .tx_rdy  (tx_rdy),
        .tx_sop  (tx_sop),
        .tx_wren (tx_wren),
        .crc_fwd (crc_fwd),
        .a_full  (a_full),
        .a_empty (a_empty)
    );

    // MAC capture, hold-stability observation and FIFO pop, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rstn && pend && tx_wren) begin
                hold_seen++;
                if (tx_data != pd || tx_sop != ps || tx_eop != pe) hold_viol++;
            end
            pend = rstn && tx_wren && !tx_rdy;
            pd   = tx_data;
            ps   = tx_sop;
            pe   = tx_eop;
            if (tx_wren && tx_rdy) beats.push_back('{tx_data, tx_sop, tx_eop, cyc});
            cons = rd_en && rd_dr;
            @(posedge clk);
            #1;
            if (cons) begin
                head++;
                rd_cnt++;
            end
            cyc++;
        end
    end

    function automatic logic [31:0] model_hdr(input int k, input logic [15:0] seq);
        logic [15:0] hw [0:21];
        logic [15:0] udp, ipl;
        int s;
        udp = 16'(10 + 4 * PW);
        ipl = 16'(udp + 16'd20);
        hw[0]  = DST_MAC[47:32]; hw[1]  = DST_MAC[31:16]; hw[2]  = DST_MAC[15:0];
        hw[3]  = SRC_MAC[47:32]; hw[4]  = SRC_MAC[31:16]; hw[5]  = SRC_MAC[15:0];
        hw[6]  = 16'h0800;       hw[7]  = 16'h4500;       hw[8]  = ipl;
        hw[9]  = 16'h0000;       hw[10] = 16'h4000;       hw[11] = 16'h4011;
        hw[12] = 16'h0000;       hw[13] = SRC_IP[31:16];  hw[14] = SRC_IP[15:0];
        hw[15] = DST_IP[31:16];  hw[16] = DST_IP[15:0];   hw[17] = SRC_PORT;
        hw[18] = DST_PORT;       hw[19] = udp;            hw[20] = 16'h0000;
        hw[21] = seq;
        s = 0;
        for (int i = 7; i <= 16; i++) s += int'(hw[i]);
        while (s > 65535) s = (s & 65535) + (s >> 16);
        hw[12] = ~s[15:0];
        return {hw[2*k], hw[2*k+1]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_frame(input string name, input int start, input logic [15:0] seq, input int pay0);
        int bad;
        logic [31:0] want, got;
        logic ws, we, gs, ge;
        bad = -1;
        want = 0; got = 0; ws = 0; we = 0; gs = 0; ge = 0;
        for (int k = 0; k < FRAME_W && bad < 0; k++) begin
            want = (k < 11) ? model_hdr(k, seq) : 32'(pay0 + k - 11);
            ws   = (k == 0);
            we   = (k == FRAME_W - 1);
            if (start + k >= beats.size()) begin
                bad = k;
                got = 32'hDEAD_DEAD;
            end else begin
                got = beats[start+k].data;
                gs  = beats[start+k].sop;
                ge  = beats[start+k].eop;
                if (got !== want || gs !== ws || ge !== we) bad = k;
            end
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s: word %0d got %h sop%b eop%b want %h sop%b eop%b",
                     name, bad, got, gs, ge, want, ws, we);
        end
    endtask

    task automatic run_frames(input int n, input bit rnd, input bit stall);
        int eops, cycles, stall_left, target;
        bit stalled;
        eops = 0; cycles = 0; stall_left = 0; stalled = 0;
        target = rd_cnt + 100;
        while (eops < n && cycles < 20000) begin
            @(negedge clk);
            if (stall && !stalled && rd_cnt == target) begin
                stalled = 1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                rd_dr = 1'b0;
                stall_left--;
            end else begin
                rd_dr = 1'b1;
            end
            tx_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (!rd_dr) begin
                tests++;
                if (tx_wren || rd_en) begin
                    fails++;
                    $display("FAIL stall_quiet: got wren=%b rd_en=%b want 0 0", tx_wren, rd_en);
                end
            end
            if (rd_en) begin
                tests++;
                if (!(tx_rdy && rd_dr && tx_wren)) begin
                    fails++;
                    $display("FAIL rd_en_gating: got rdy=%b dr=%b wren=%b want 1 1 1", tx_rdy, rd_dr, tx_wren);
                end
            end
            if (tx_eop && tx_wren && tx_rdy) eops++;
            if (eops == n) a_empty = 1'b1;
            cycles++;
        end
        rd_dr = 1'b1;
        tx_rdy = 1'b1;
        if (eops < n) begin
            tests++;
            fails++;
            $display("FAIL frame_timeout: got %0d eops want %0d", eops, n);
        end
    endtask

    vec_t vecs[18];
    int   c_base, d_base, e_base, cnt, gap;
    bit   found;

    initial begin
        vecs[0]  = '{0,   32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[1]  = '{1,   32'hFFFF0200, 1'b0, 1'b0};
        vecs[2]  = '{2,   32'hC0A8010A, 1'b0, 1'b0};
        vecs[3]  = '{3,   32'h08004500, 1'b0, 1'b0};
        vecs[4]  = '{4,   32'h041E0000, 1'b0, 1'b0};
        vecs[5]  = '{5,   32'h40004011, 1'b0, 1'b0};
        vecs[6]  = '{6,   32'hB373C0A8, 1'b0, 1'b0};
        vecs[7]  = '{7,   32'h010AC0A8, 1'b0, 1'b0};
        vecs[8]  = '{8,   32'h01011388, 1'b0, 1'b0};
        vecs[9]  = '{9,   32'h1388040A, 1'b0, 1'b0};
        vecs[10] = '{10,  32'h00000000, 1'b0, 1'b0};
        vecs[11] = '{11,  32'h00000000, 1'b0, 1'b0};
        vecs[12] = '{12,  32'h00000001, 1'b0, 1'b0};
        vecs[13] = '{266, 32'h000000FF, 1'b0, 1'b1};
        vecs[14] = '{267, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[15] = '{277, 32'h00000001, 1'b0, 1'b0};
        vecs[16] = '{278, 32'h00000100, 1'b0, 1'b0};
        vecs[17] = '{533, 32'h000001FF, 1'b0, 1'b1};

        rstn = 1'b0; a_empty = 1'b1; rd_dr = 1'b1; tx_rdy = 1'b1; a_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wren",  32'(tx_wren), 32'd0);
        chk("rst_sop",   32'(tx_sop),  32'd0);
        chk("rst_eop",   32'(tx_eop),  32'd0);
        chk("rst_rd_en", 32'(rd_en),   32'd0);
        chk("rst_data",  tx_data,      32'd0);
        chk("const_err_mod_crc", {29'd0, tx_err, tx_mod}, 32'd0);
        chk("const_crc_fwd", 32'(crc_fwd), 32'd0);

        // a_empty held high: no frame may start.
        @(negedge clk);
        rstn = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (tx_wren || tx_sop) cnt++;
        end
        chk("no_tx_while_a_empty", 32'(cnt), 32'd0);
        c_base = beats.size();
        @(negedge clk);
        a_empty = 1'b0;
        found = 0;
        for (int i = 0; i < 2 && !found; i++) begin
            @(negedge clk);
            #1;
            if (tx_sop && tx_wren) found = 1;
        end
        chk("sop_after_a_empty_drop", 32'(found), 32'd1);

        // Two back-to-back frames at full rate.
        run_frames(2, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        for (int v = 0; v < 18; v++) begin
            if (c_base + vecs[v].off < beats.size()) begin
                chk($sformatf("vec%0d_data", v), beats[c_base+vecs[v].off].data, vecs[v].data);
                chk($sformatf("vec%0d_flags", v),
                    {30'd0, beats[c_base+vecs[v].off].sop, beats[c_base+vecs[v].off].eop},
                    {30'd0, vecs[v].sop, vecs[v].eop});
            end else begin
                tests++;
                fails++;
                $display("FAIL vec%0d_missing: got %0d beats want > %0d", v, beats.size() - c_base, vecs[v].off);
            end
        end
        check_frame("frame0", c_base, 16'd0, 0);
        check_frame("frame1", c_base + FRAME_W, 16'd1, PW);
        chk("rd_en_count", 32'(rd_cnt), 32'(2 * PW));
        if (c_base + FRAME_W < beats.size()) begin
            gap = beats[c_base+FRAME_W].cyc - beats[c_base+FRAME_W-1].cyc - 1;
            tests++;
            if (gap < IGAP) begin
                fails++;
                $display("FAIL eop_sop_gap: got %0d idle cycles want >= %0d", gap, IGAP);
            end
        end

        // Random MAC back-pressure plus a 5-cycle FIFO stall mid-payload.
        d_base = beats.size();
        a_empty = 1'b0;
        run_frames(2, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check_frame("frame2_backpressure", d_base, 16'd2, 2 * PW);
        check_frame("frame3_backpressure", d_base + FRAME_W, 16'd3, 3 * PW);
        chk("beats_total_after_bp", 32'(beats.size() - d_base), 32'(2 * FRAME_W));
        chk("hold_violations", 32'(hold_viol), 32'd0);
        chk("hold_exercised", 32'(hold_seen > 0), 32'd1);

        // Reset while header word 5 is on the bus.
        a_empty = 1'b0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            #1;
            if (tx_sop && tx_wren) found = 1;
        end
        chk("sop_before_reset", 32'(found), 32'd1);
        repeat (5) @(negedge clk);
        #1;
        chk("hdr_w5_before_reset", tx_data, 32'h40004011);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_abort_wren", 32'(tx_wren), 32'd0);
        chk("reset_abort_eop",  32'(tx_eop),  32'd0);
        chk("reset_abort_data", tx_data,      32'd0);
        rstn = 1'b1;
        e_base = beats.size();
        run_frames(1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        if (e_base + 10 < beats.size()) begin
            chk("post_reset_sop", 32'(beats[e_base].sop), 32'd1);
            chk("post_reset_w10", beats[e_base+10].data, 32'h00000000);
        end else begin
            tests++;
            fails++;
            $display("FAIL post_reset_frame: got %0d beats want >= 11", beats.size() - e_base);
        end
        check_frame("frame_after_reset", e_base, 16'd0, 4 * PW);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
